// File: rtl/calc_sequencer.sv
// Central control FSM for the four-digit slider calculator: sequences operand entry,
// supervises the multi-cycle ALU request and selects what the display shows.
module calc_sequencer #(
   parameter int WIDTH          = 14,
   parameter int MAX_VALUE      = 9999,
   parameter int ALU_TIMEOUT    = 255,
   parameter int BLINK_OVERFLOW = 2**24-1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_ent,
   input  logic             btn_clr,
   input  logic             op_sel,
   input  logic [WIDTH-1:0] number_1,
   input  logic [WIDTH-1:0] number_2,
   output logic             write_sel,
   output logic             edit_en,
   output logic             edit_clr,
   output logic             alu_start,
   output logic             alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] display_number,
   output logic             display_blank,
   output logic [2:0]       phase
);

   localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT + 1) : 1;
   localparam int BW = (BLINK_OVERFLOW > 1) ? $clog2(BLINK_OVERFLOW + 1) : 1;
   localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(ALU_TIMEOUT);
   localparam logic [BW-1:0]    BLINK_LAST   = BW'(BLINK_OVERFLOW);
   localparam logic [WIDTH-1:0] MAX_W        = WIDTH'(MAX_VALUE);

   typedef enum logic [2:0] {
      EDIT_A  = 3'd0,
      EDIT_B  = 3'd1,
      COMPUTE = 3'd2,
      SHOW    = 3'd3,
      ERROR   = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_writeSel;
   logic             r_editEn;
   logic             r_editClr;
   logic             r_aluStart;
   logic             r_aluOp;
   logic [WIDTH-1:0] r_aluA;
   logic [WIDTH-1:0] r_aluB;
   logic [WIDTH-1:0] r_result;
   logic [TW-1:0]    r_tmoCnt;
   logic [BW-1:0]    r_blinkCnt;
   logic             r_blank;
   logic [WIDTH-1:0] w_display;

   // btn_clr overrides everything; alu_done only matters while COMPUTE is active
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= EDIT_A;
         r_writeSel <= 1'b0;
         r_editEn   <= 1'b1;
         r_editClr  <= 1'b0;
         r_aluStart <= 1'b0;
         r_aluOp    <= 1'b0;
         r_aluA     <= '0;
         r_aluB     <= '0;
         r_result   <= '0;
         r_tmoCnt   <= '0;
         r_blinkCnt <= '0;
         r_blank    <= 1'b0;
      end else begin
         r_editClr  <= 1'b0;
         r_aluStart <= 1'b0;
         if (btn_clr) begin
            r_state    <= EDIT_A;
            r_editEn   <= 1'b1;
            r_writeSel <= 1'b0;
            r_editClr  <= 1'b1;
         end else begin
            case (r_state)
               EDIT_A: begin
                  if (btn_ent) begin
                     r_aluA     <= number_1;
                     r_writeSel <= 1'b1;
                     r_state    <= EDIT_B;
                  end
               end
               EDIT_B: begin
                  if (btn_ent) begin
                     r_aluB     <= number_2;
                     r_aluOp    <= op_sel;
                     r_aluStart <= 1'b1;
                     r_tmoCnt   <= '0;
                     r_editEn   <= 1'b0;
                     r_state    <= COMPUTE;
                  end
               end
               COMPUTE: begin
                  // a done in the timeout cycle still counts as a valid answer
                  if (alu_done) begin
                     if (alu_ovf || (alu_result > MAX_W)) begin
                        r_state    <= ERROR;
                        r_blinkCnt <= '0;
                        r_blank    <= 1'b0;
                     end else begin
                        r_result <= alu_result;
                        r_state  <= SHOW;
                     end
                  end else if (r_tmoCnt == TIMEOUT_LAST) begin
                     r_state    <= ERROR;
                     r_blinkCnt <= '0;
                     r_blank    <= 1'b0;
                  end else begin
                     r_tmoCnt <= r_tmoCnt + TW'(1);
                  end
               end
               SHOW: begin
                  if (btn_ent) begin
                     r_editEn   <= 1'b1;
                     r_writeSel <= 1'b0;
                     r_state    <= EDIT_A;
                  end
               end
               ERROR: begin
                  if (r_blinkCnt == BLINK_LAST) begin
                     r_blinkCnt <= '0;
                     r_blank    <= ~r_blank;
                  end else begin
                     r_blinkCnt <= r_blinkCnt + BW'(1);
                  end
                  if (btn_ent) begin
                     r_editClr  <= 1'b1;
                     r_editEn   <= 1'b1;
                     r_writeSel <= 1'b0;
                     r_state    <= EDIT_A;
                  end
               end
               default: r_state <= EDIT_A;
            endcase
         end
      end
   end

   // Edit states mirror the live slider operands; later states show latched values
   always_comb begin
      w_display = number_1;
      case (r_state)
         EDIT_A:  w_display = number_1;
         EDIT_B:  w_display = number_2;
         COMPUTE: w_display = r_aluB;
         SHOW:    w_display = r_result;
         ERROR:   w_display = MAX_W;
         default: w_display = number_1;
      endcase
   end

   assign display_number = w_display;
   assign display_blank  = (r_state == ERROR) && r_blank;
   assign write_sel      = r_writeSel;
   assign edit_en        = r_editEn;
   assign edit_clr       = r_editClr;
   assign alu_start      = r_aluStart;
   assign alu_op         = r_aluOp;
   assign alu_a          = r_aluA;
   assign alu_b          = r_aluB;
   assign phase          = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: vector table, hand-written corner sequences and
// randomized calculations checked against a transaction-level model.
module tb_calc_sequencer;

   localparam int W = 14;

   logic          clk = 1'b0;
   logic          reset;
   logic          btnEnt, btnClr, opSel;
   logic [W-1:0]  number1, number2;
   logic          writeSel, editEn, editClr, aluStart, aluOp;
   logic [W-1:0]  aluA, aluB;
   logic          aluDone, aluOvf;
   logic [W-1:0]  aluResult;
   logic [W-1:0]  displayNumber;
   logic          displayBlank;
   logic [2:0]    phase;

   int checks   = 0;
   int failures = 0;

   calc_sequencer #(
      .WIDTH(W), .MAX_VALUE(9999), .ALU_TIMEOUT(8), .BLINK_OVERFLOW(3)
   ) dut (
      .clk(clk), .reset(reset), .btn_ent(btnEnt), .btn_clr(btnClr), .op_sel(opSel),
      .number_1(number1), .number_2(number2),
      .write_sel(writeSel), .edit_en(editEn), .edit_clr(editClr),
      .alu_start(aluStart), .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB),
      .alu_done(aluDone), .alu_result(aluResult), .alu_ovf(aluOvf),
      .display_number(displayNumber), .display_blank(displayBlank), .phase(phase)
   );

   always #5 clk = ~clk;

   // Safety net so the bench always ends on its own
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   typedef struct {
      logic          ent, clr, done, ovf, op;
      logic [W-1:0]  res, n1, n2;
      logic [2:0]    expPhase;
      logic          expEditEn, expWriteSel, expEditClr, expStart;
      logic [W-1:0]  expDisp, expA, expB;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic ent, clr, done, input int res, input int n1, n2,
                               input int ph, input logic en, ws, ec, st,
                               input int disp, a, b);
      vec_t v;
      v.ent = ent; v.clr = clr; v.done = done; v.ovf = 1'b0; v.op = 1'b0;
      v.res = W'(res); v.n1 = W'(n1); v.n2 = W'(n2);
      v.expPhase = 3'(ph); v.expEditEn = en; v.expWriteSel = ws;
      v.expEditClr = ec; v.expStart = st;
      v.expDisp = W'(disp); v.expA = W'(a); v.expB = W'(b);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic checkCore(input string tag, input int ph, input logic en, ws, ec, st, input int disp);
      checkOutput({tag, " phase"}, 32'(phase), 32'(ph));
      checkOutput({tag, " edit_en"}, 32'(editEn), 32'(en));
      checkOutput({tag, " write_sel"}, 32'(writeSel), 32'(ws));
      checkOutput({tag, " edit_clr"}, 32'(editClr), 32'(ec));
      checkOutput({tag, " alu_start"}, 32'(aluStart), 32'(st));
      checkOutput({tag, " display"}, 32'(displayNumber), 32'(disp));
   endtask

   // Drives one cycle of button/ALU inputs and returns #1 after the sampling edge
   task automatic applyStimulus(input logic ent, clr, done, input logic [W-1:0] res, input logic ovf);
      btnEnt = ent; btnClr = clr; aluDone = done; aluResult = res; aluOvf = ovf;
      @(posedge clk); #1;
      btnEnt = 1'b0; btnClr = 1'b0; aluDone = 1'b0; aluOvf = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkCore(tag, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'(number1));
      checkOutput({tag, " alu_op"}, 32'(aluOp), 32'd0);
      checkOutput({tag, " alu_a"}, 32'(aluA), 32'd0);
      checkOutput({tag, " alu_b"}, 32'(aluB), 32'd0);
      checkOutput({tag, " blank"}, 32'(displayBlank), 32'd0);
   endtask

   // Enters A then B, leaving the bench #1 into the alu_start cycle
   task automatic startCalc(input logic [W-1:0] a, b, input logic op);
      number1 = a;
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      number2 = b; opSel = op;
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int firstErr;
      reset = 1'b1; btnEnt = 0; btnClr = 0; opSel = 0; aluDone = 0; aluOvf = 0;
      aluResult = '0; number1 = 14'd42; number2 = '0;
      @(posedge clk); #1;
      doReset();
      checkResetState("reset");

      vecs[0]  = mk(1,0,0,0,    1234,0,    1,1,1,0,0, 0,    1234,0);
      vecs[1]  = mk(0,0,0,0,    1234,4321, 1,1,1,0,0, 4321, 1234,0);
      vecs[2]  = mk(1,0,0,0,    1234,4321, 2,0,1,0,1, 4321, 1234,4321);
      vecs[3]  = mk(0,0,0,0,    1234,4321, 2,0,1,0,0, 4321, 1234,4321);
      vecs[4]  = mk(1,0,0,0,    1234,4321, 2,0,1,0,0, 4321, 1234,4321);
      vecs[5]  = mk(0,0,0,0,    1234,4321, 2,0,1,0,0, 4321, 1234,4321);
      vecs[6]  = mk(0,0,1,5555, 1234,4321, 3,0,1,0,0, 5555, 1234,4321);
      vecs[7]  = mk(0,0,0,0,    777,4321,  3,0,1,0,0, 5555, 1234,4321);
      vecs[8]  = mk(1,0,0,0,    777,4321,  0,1,0,0,0, 777,  1234,4321);
      vecs[9]  = mk(1,0,0,0,    100,4321,  1,1,1,0,0, 4321, 100,4321);
      vecs[10] = mk(1,1,0,0,    100,4321,  0,1,0,1,0, 100,  100,4321);
      vecs[11] = mk(0,0,0,0,    100,4321,  0,1,0,0,0, 100,  100,4321);

      for (int i = 0; i < 12; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         number1 = vecs[i].n1; number2 = vecs[i].n2; opSel = vecs[i].op;
         applyStimulus(vecs[i].ent, vecs[i].clr, vecs[i].done, vecs[i].res, vecs[i].ovf);
         checkCore(tag, int'(vecs[i].expPhase), vecs[i].expEditEn, vecs[i].expWriteSel,
                   vecs[i].expEditClr, vecs[i].expStart, int'(vecs[i].expDisp));
         checkOutput({tag, " alu_a"}, 32'(aluA), 32'(vecs[i].expA));
         checkOutput({tag, " alu_b"}, 32'(aluB), 32'(vecs[i].expB));
      end

      // Reset while showing a result
      startCalc(14'd100, 14'd5, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 14'd42, 1'b0);
      checkCore("showPreReset", 3, 1'b0, 1'b1, 1'b0, 1'b0, 42);
      doReset();
      checkResetState("resetInShow");
      number1 = 14'd3210; #1;
      checkOutput("resetInShow follow", 32'(displayNumber), 32'd3210);

      // Overflow by value, blink cadence, then recovery
      startCalc(14'd9000, 14'd2000, 1'b0);
      checkOutput("ovf alu_a", 32'(aluA), 32'd9000);
      applyStimulus(1'b0, 1'b0, 1'b1, 14'd11000, 1'b0);
      checkCore("ovf error", 4, 1'b0, 1'b1, 1'b0, 1'b0, 9999);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("blink%0d", i), 32'(displayBlank), 32'((i / 4) % 2));
         idle(1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkCore("errEnt", 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'(number1));
      checkOutput("errEnt blank", 32'(displayBlank), 32'd0);
      idle(1);
      checkOutput("errEnt clrDrop", 32'(editClr), 32'd0);

      // ALU never answers: error exactly 9 cycles after alu_start
      startCalc(14'd1, 14'd2, 1'b0);
      checkOutput("tmo start", 32'(aluStart), 32'd1);
      firstErr = 0;
      for (int k = 1; k <= 12 && firstErr == 0; k++) begin
         idle(1);
         if (phase == 3'd4) firstErr = k;
      end
      checkOutput("tmo latency", 32'(firstErr), 32'd9);
      applyStimulus(1'b0, 1'b0, 1'b1, 14'd5, 1'b0);
      checkCore("tmo lateDone", 4, 1'b0, 1'b1, 1'b0, 1'b0, 9999);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkCore("tmo clr", 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'(number1));

      // Done arriving in the very cycle the timeout fires still wins
      startCalc(14'd3, 14'd4, 1'b0);
      idle(8);
      checkOutput("tmoEdge compute", 32'(phase), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b1, 14'd77, 1'b0);
      checkCore("tmoEdge show", 3, 1'b0, 1'b1, 1'b0, 1'b0, 77);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Clear one cycle after alu_start, stale done two cycles later
      doReset();
      startCalc(14'd11, 14'd22, 1'b0);
      idle(1);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checkCore("abort clr", 0, 1'b1, 1'b0, 1'b1, 1'b0, 11);
      idle(1);
      checkOutput("abort clrOnce", 32'(editClr), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 14'd999, 1'b0);
      checkCore("abort lateDone", 0, 1'b1, 1'b0, 1'b0, 1'b0, 11);

      // Randomized calculations against the transaction model
      for (int t = 0; t < 40; t++) begin
         logic [W-1:0] a, b, res;
         logic op, ovf, timeout, expErr, useClr;
         int waitCycles;
         string tag;
         tag = $sformatf("rnd%0d", t);
         a = W'($urandom_range(0, 9999));
         b = W'($urandom_range(0, 9999));
         op = 1'($urandom_range(0, 1));
         timeout = ($urandom_range(0, 9) == 0);
         res = W'($urandom_range(0, 16383));
         ovf = ($urandom_range(0, 7) == 0);
         waitCycles = $urandom_range(0, 5);
         useClr = ($urandom_range(0, 3) == 0);
         expErr = timeout || ovf || (int'(res) > 9999);

         startCalc(a, b, op);
         checkCore({tag, " issue"}, 2, 1'b0, 1'b1, 1'b0, 1'b1, 32'(b));
         checkOutput({tag, " alu_a"}, 32'(aluA), 32'(a));
         checkOutput({tag, " alu_op"}, 32'(aluOp), 32'(op));
         if (timeout) begin
            idle(9);
         end else begin
            idle(waitCycles);
            applyStimulus(1'b0, 1'b0, 1'b1, res, ovf);
         end
         checkOutput({tag, " outcome"}, 32'(phase), expErr ? 32'd4 : 32'd3);
         checkOutput({tag, " result"}, 32'(displayNumber), expErr ? 32'd9999 : 32'(res));
         applyStimulus(!useClr, useClr, 1'b0, '0, 1'b0);
         checkOutput({tag, " back"}, 32'(phase), 32'd0);
         checkOutput({tag, " edit_clr"}, 32'(editClr), 32'(useClr || expErr));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
